// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, state encoding and reset PC for the fetch sequencer
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERROR} fetch_state_e;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: clear/enable cycle counter flagging the last allowed wait cycle
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + W'(1);
    end
    assign o_expire = r_count == LAST;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-outstanding instruction fetch sequencer driving PC control,
// the imem request/response channels and the decode handshake.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_block_increment,
    output logic            pc_is_addr,
    output logic [XLEN-1:0] pc_in_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            halt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_error
);
    fetch_state_e    r_state, w_next, w_after;
    logic            r_drop;
    logic [XLEN-1:0] r_req_pc, r_inst_data, r_inst_pc;
    logic            w_accept, w_drop, w_expire;

    assign pc_in_addr         = redirect_addr;
    assign pc_is_addr         = redirect_valid && r_state != ERROR;
    assign imem_req_valid     = r_state == REQ && !redirect_valid;
    assign imem_req_addr      = pc_addr;
    assign w_accept           = imem_req_valid && imem_req_ready;
    assign pc_block_increment = !w_accept;
    assign inst_valid         = r_state == HOLD && !redirect_valid;
    assign inst_data          = r_inst_data;
    assign inst_pc            = r_inst_pc;
    assign fetch_error        = r_state == ERROR;
    // A redirect coinciding with the response also kills it: the PC has already moved.
    assign w_drop             = r_drop || redirect_valid;
    assign w_after            = halt ? IDLE : REQ;

    fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk,
        .reset,
        .i_clr   (w_accept),
        .i_en    (r_state == WAIT && !imem_rsp_valid),
        .o_expire(w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_after;
            REQ:     w_next = w_accept ? WAIT : REQ;
            WAIT:    w_next = imem_rsp_valid ? (w_drop ? w_after : HOLD) : (w_expire ? ERROR : WAIT);
            HOLD:    w_next = (redirect_valid || inst_ready) ? w_after : HOLD;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drop      <= 1'b0;
            r_req_pc    <= '0;
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req_pc <= pc_addr;
                r_drop   <= 1'b0;
            end else if (r_state == WAIT)
                r_drop <= imem_rsp_valid ? 1'b0 : w_drop;
            if (r_state == WAIT && imem_rsp_valid && !w_drop) begin
                r_inst_data <= imem_rsp_data;
                r_inst_pc   <= r_req_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scenario tasks with a PC register model, an imem responder
// and a queue of expected decode transfers.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_block_increment, pc_is_addr;
    logic [31:0] pc_in_addr;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        fetch_error;

    bit          mem_on;
    int          mem_lat;
    logic [31:0] mem_word;
    int          rsp_cnt;
    bit          rsp_acc;
    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    fetch_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr),
        .pc_block_increment(pc_block_increment), .pc_is_addr(pc_is_addr), .pc_in_addr(pc_in_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    // PC register: load has priority over increment
    always @(posedge clk or posedge reset) begin
        if (reset)
            pc_addr <= RESET_PC;
        else if (pc_is_addr)
            pc_addr <= pc_in_addr;
        else if (!pc_block_increment)
            pc_addr <= pc_addr + 32'd4;
    end

    // imem: responds mem_lat cycles after an accepted request (ignores reset on purpose)
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        rsp_cnt = 0;
        forever begin
            @(negedge clk);
            rsp_acc = imem_req_valid && imem_req_ready && mem_on;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (rsp_acc) rsp_cnt = mem_lat;
            if (rsp_cnt == 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word;
            end
            if (rsp_cnt > 0) rsp_cnt--;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        tick;
        reset = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_on = 1'b1;
        mem_lat = 1;
        mem_word = 32'h0000_0013;
        exp_q.delete();
        tick;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic await_inst(input int budget, output bit got, output logic [31:0] pc, output logic [31:0] data);
        got = 1'b0;
        pc = '0;
        data = '0;
        for (int i = 0; i < budget && !got; i++) begin
            #1;
            if (inst_valid && inst_ready) begin
                got = 1'b1;
                pc = inst_pc;
                data = inst_data;
            end else
                tick;
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid, fetch_error, pc_block_increment, pc_is_addr} !== 5'b00010) begin
            failures++;
            $display("FAIL reset_ctrl: got rv/iv/err/bi/ld=%b required 00010",
                     {imem_req_valid, inst_valid, fetch_error, pc_block_increment, pc_is_addr});
        end
        checks++;
        if ({inst_data, inst_pc} !== 64'h0) begin
            failures++;
            $display("FAIL reset_inst: got data=%h pc=%h required 0/0", inst_data, inst_pc);
        end
    endtask

    task automatic test_basic;
        bit          exp_bi[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
        bit          exp_iv[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        logic [31:0] nxt = RESET_PC;
        exp_t        e;
        apply_reset;
        exp_q.push_back('{RESET_PC, 32'h0000_0013});
        exp_q.push_back('{RESET_PC + 32'd4, 32'h0000_0013});
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if (pc_block_increment !== exp_bi[i]) begin
                failures++;
                $display("FAIL basic_block_inc c%0d: got %b required %b", i, pc_block_increment, exp_bi[i]);
            end
            checks++;
            if (inst_valid !== exp_iv[i]) begin
                failures++;
                $display("FAIL basic_inst_valid c%0d: got %b required %b", i, inst_valid, exp_iv[i]);
            end
            if (!exp_bi[i]) begin
                checks++;
                if (imem_req_addr !== nxt) begin
                    failures++;
                    $display("FAIL basic_req_addr c%0d: got %h required %h", i, imem_req_addr, nxt);
                end
                nxt += 32'd4;
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_extra_inst: got pc=%h required none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                        failures++;
                        $display("FAIL basic_inst: got pc=%h data=%h required pc=%h data=%h",
                                 inst_pc, inst_data, e.pc, e.data);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_missing: got %0d undelivered required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_wait;
        bit got;
        logic [31:0] p, d;
        exp_t e;
        apply_reset;
        mem_lat = 2;
        mem_word = 32'hDEAD_BEEF;
        tick;
        tick;
        redirect_valid = 1'b1;
        redirect_addr = 32'h8000_0100;
        #1;
        checks++;
        if ({pc_is_addr, pc_in_addr} !== {1'b1, 32'h8000_0100}) begin
            failures++;
            $display("FAIL rdw_load: got ld=%b addr=%h required 1 80000100", pc_is_addr, pc_in_addr);
        end
        tick;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdw_dropped: got inst_valid=%b required 0", inst_valid);
        end
        tick;
        mem_word = 32'h0050_0093;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
            failures++;
            $display("FAIL rdw_next_req: got v=%b addr=%h required 1 80000100", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back('{32'h8000_0100, 32'h0050_0093});
        await_inst(12, got, p, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {p, d} !== {e.pc, e.data}) begin
            failures++;
            $display("FAIL rdw_inst: got seen=%b pc=%h data=%h required pc=%h data=%h", got, p, d, e.pc, e.data);
        end
    endtask

    task automatic test_backpressure;
        bit got;
        logic [31:0] p, d;
        exp_t e;
        apply_reset;
        mem_word = 32'h00A0_0113;
        inst_ready = 1'b0;
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            #1;
            checks++;
            if ({inst_valid, imem_req_valid, pc_block_increment, inst_pc, inst_data} !==
                {1'b1, 1'b0, 1'b1, RESET_PC, 32'h00A0_0113}) begin
                failures++;
                $display("FAIL bp_hold c%0d: got iv=%b rv=%b bi=%b pc=%h data=%h required 1 0 1 %h 00a00113",
                         i, inst_valid, imem_req_valid, pc_block_increment, inst_pc, inst_data, RESET_PC);
            end
        end
        exp_q.push_back('{RESET_PC, 32'h00A0_0113});
        tick;
        inst_ready = 1'b1;
        await_inst(3, got, p, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {p, d} !== {e.pc, e.data}) begin
            failures++;
            $display("FAIL bp_release: got seen=%b pc=%h data=%h required pc=%h data=%h", got, p, d, e.pc, e.data);
        end
    endtask

    task automatic test_timeout;
        apply_reset;
        mem_on = 1'b0;
        repeat (17) tick;
        #1;
        checks++;
        if (fetch_error !== 1'b0) begin
            failures++;
            $display("FAIL to_early: got fetch_error=%b on 16th wait cycle required 0", fetch_error);
        end
        tick;
        #1;
        checks++;
        if (fetch_error !== 1'b1) begin
            failures++;
            $display("FAIL to_set: got fetch_error=%b required 1", fetch_error);
        end
        tick;
        redirect_valid = 1'b1;
        redirect_addr = 32'h8000_0400;
        #1;
        checks++;
        if ({pc_is_addr, imem_req_valid, inst_valid} !== 3'b000) begin
            failures++;
            $display("FAIL to_error_outputs: got ld/rv/iv=%b required 000", {pc_is_addr, imem_req_valid, inst_valid});
        end
        redirect_valid = 1'b0;
        repeat (4) tick;
        #1;
        checks++;
        if (fetch_error !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: got fetch_error=%b required 1", fetch_error);
        end
    endtask

    task automatic test_rsp_at_expiry;
        apply_reset;
        mem_lat = 16;
        mem_word = 32'h0010_0073;
        repeat (18) tick;
        #1;
        checks++;
        if ({inst_valid, fetch_error, inst_pc, inst_data} !== {1'b1, 1'b0, RESET_PC, 32'h0010_0073}) begin
            failures++;
            $display("FAIL exp_rsp_wins: got iv=%b err=%b pc=%h data=%h required 1 0 %h 00100073",
                     inst_valid, fetch_error, inst_pc, inst_data, RESET_PC);
        end
    endtask

    task automatic test_redirect_req;
        bit got;
        logic [31:0] p, d;
        exp_t e;
        apply_reset;
        tick;
        redirect_valid = 1'b1;
        redirect_addr = 32'h8000_0200;
        #1;
        checks++;
        if ({imem_req_valid, pc_is_addr, pc_block_increment, pc_in_addr} !== {3'b011, 32'h8000_0200}) begin
            failures++;
            $display("FAIL rdr_withdraw: got rv/ld/bi=%b addr=%h required 011 80000200",
                     {imem_req_valid, pc_is_addr, pc_block_increment}, pc_in_addr);
        end
        tick;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0200}) begin
            failures++;
            $display("FAIL rdr_new_req: got v=%b addr=%h required 1 80000200", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back('{32'h8000_0200, 32'h0000_0013});
        await_inst(8, got, p, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {p, d} !== {e.pc, e.data}) begin
            failures++;
            $display("FAIL rdr_inst: got seen=%b pc=%h data=%h required pc=%h data=%h", got, p, d, e.pc, e.data);
        end
    endtask

    task automatic test_halt;
        apply_reset;
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            #1;
            checks++;
            if ({imem_req_valid, pc_block_increment} !== 2'b01) begin
                failures++;
                $display("FAIL halt_idle c%0d: got rv/bi=%b required 01", i, {imem_req_valid, pc_block_increment});
            end
        end
        tick;
        halt = 1'b0;
        tick;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
            failures++;
            $display("FAIL halt_resume: got v=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit got;
        logic [31:0] p, d;
        exp_t e;
        apply_reset;
        exp_q.push_back('{RESET_PC, 32'h0000_0013});
        await_inst(6, got, p, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {p, d} !== {e.pc, e.data}) begin
            failures++;
            $display("FAIL rmw_first: got seen=%b pc=%h data=%h required pc=%h data=%h", got, p, d, e.pc, e.data);
        end
        mem_lat = 3;
        mem_word = 32'hBAD0_BAD0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid, fetch_error, pc_block_increment, pc_is_addr, inst_data, inst_pc} !==
            {5'b00010, 64'h0}) begin
            failures++;
            $display("FAIL rmw_async: got rv/iv/err/bi/ld=%b data=%h pc=%h required 00010 0 0",
                     {imem_req_valid, inst_valid, fetch_error, pc_block_increment, pc_is_addr}, inst_data, inst_pc);
        end
        tick;
        reset = 1'b0;
        tick;
        #1;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {2'b01, RESET_PC}) begin
            failures++;
            $display("FAIL rmw_restart: got iv=%b rv=%b addr=%h required 0 1 %h",
                     inst_valid, imem_req_valid, imem_req_addr, RESET_PC);
        end
        exp_q.push_back('{RESET_PC, 32'h0030_0193});
        tick;
        mem_word = 32'h0030_0193;
        await_inst(8, got, p, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {p, d} !== {e.pc, e.data}) begin
            failures++;
            $display("FAIL rmw_inst: got seen=%b pc=%h data=%h required pc=%h data=%h", got, p, d, e.pc, e.data);
        end
    endtask

    initial begin
        reset = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_on = 1'b1;
        mem_lat = 1;
        mem_word = 32'h0000_0013;
        test_reset;
        test_basic;
        test_redirect_wait;
        test_backpressure;
        test_timeout;
        test_rsp_at_expiry;
        test_redirect_req;
        test_halt;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
